// File: rtl/pcs_lock_pkg.sv
// Shared types and helpers for the 64b/66b block-lock path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: lock_state_t lane FSM states, the two legal sync header codes,
// and sh_is_valid() which classifies a 2-bit sync header.
package pcs_lock_pkg;

   typedef enum logic {
      TEST      = 1'b0,
      SLIP_WAIT = 1'b1
   } lock_state_t;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   // Only 01 (data) and 10 (control) are legal; 00 and 11 indicate misalignment.
   function automatic logic sh_is_valid(input logic [1:0] sh);
      return (sh == SYNC_DATA) || (sh == SYNC_CTRL);
   endfunction

endpackage

// File: rtl/block_lock_lane.sv
// One lane of 64b/66b block lock: window test, slip request, settle wait, slip stats.
// Latency: outputs registered, one cycle after the edge sampling the header.
// Backpressure: none; lane state advances only on edges with valid=1, holds otherwise.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   valid, header    header qualifier and 2-bit sync header from the gearbox
//   clear_counts     synchronous clear of slip_count (beats a same-cycle slip)
//   slip             one-cycle slip request to the gearbox
//   block_lock       registered lock status
//   block_lock_next  next-state lock, lets the parent register an aligned aggregate
//   slip_count       saturating count of slips issued
module block_lock_lane #(
   parameter int WINDOW      = 64,
   parameter int INVALID_MAX = 16,
   parameter int SLIP_WAIT   = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid,
   input  logic [1:0] header,
   input  logic       clear_counts,
   output logic       slip,
   output logic       block_lock,
   output logic       block_lock_next,
   output logic [7:0] slip_count
);
   import pcs_lock_pkg::*;

   localparam int CW = $clog2(WINDOW + 1);

   lock_state_t   state, state_n;
   logic [CW-1:0] sh_cnt, sh_cnt_n;
   logic [CW-1:0] sh_invalid_cnt, sh_invalid_cnt_n;
   logic [7:0]    wait_cnt, wait_cnt_n;
   logic          lock_n;
   logic          slip_n;

   logic          hdr_ok;
   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] inv_inc;
   logic [8:0]    wait_inc;

   assign hdr_ok   = sh_is_valid(header);
   assign cnt_inc  = sh_cnt + 1'b1;
   assign inv_inc  = sh_invalid_cnt + CW'(!hdr_ok);
   assign wait_inc = {1'b0, wait_cnt} + 9'd1;

   always_comb begin
      state_n          = state;
      sh_cnt_n         = sh_cnt;
      sh_invalid_cnt_n = sh_invalid_cnt;
      wait_cnt_n       = wait_cnt;
      lock_n           = block_lock;
      slip_n           = 1'b0;
      if (valid) begin
         if (state == TEST) begin
            // Slip check wins over the window-end check on the same header.
            if (!hdr_ok && (!block_lock || inv_inc == CW'(INVALID_MAX))) begin
               lock_n           = 1'b0;
               slip_n           = 1'b1;
               sh_cnt_n         = '0;
               sh_invalid_cnt_n = '0;
               state_n          = (SLIP_WAIT == 0) ? TEST : pcs_lock_pkg::SLIP_WAIT;
            end else if (cnt_inc == CW'(WINDOW)) begin
               // A clean window grants lock; a window with tolerated errors keeps status.
               if (inv_inc == '0) begin
                  lock_n = 1'b1;
               end
               sh_cnt_n         = '0;
               sh_invalid_cnt_n = '0;
            end else begin
               sh_cnt_n         = cnt_inc;
               sh_invalid_cnt_n = inv_inc;
            end
         end else begin
            // Gearbox is still settling; header content is ignored here.
            if (wait_inc == 9'(SLIP_WAIT)) begin
               wait_cnt_n = '0;
               state_n    = TEST;
            end else begin
               wait_cnt_n = wait_inc[7:0];
            end
         end
      end
   end

   assign block_lock_next = lock_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= TEST;
         sh_cnt         <= '0;
         sh_invalid_cnt <= '0;
         wait_cnt       <= '0;
         block_lock     <= 1'b0;
         slip           <= 1'b0;
         slip_count     <= '0;
      end else begin
         state          <= state_n;
         sh_cnt         <= sh_cnt_n;
         sh_invalid_cnt <= sh_invalid_cnt_n;
         wait_cnt       <= wait_cnt_n;
         block_lock     <= lock_n;
         slip           <= slip_n;
         if (clear_counts) begin
            slip_count <= '0;
         end else if (slip_n && slip_count != 8'hFF) begin
            slip_count <= slip_count + 8'd1;
         end
      end
   end

endmodule

// File: rtl/block_lock_multi.sv
// Multi-lane 64b/66b block lock with per-lane slip stats and an all-lanes-locked flag.
// Latency: all outputs registered, one cycle after the sampling edge.
// Backpressure: none; each lane advances only on its own i_valid bit.
//
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_valid          per-lane header qualifier, lane i at bit i
//   i_header         sync headers, lane i at [2i+1:2i]
//   i_clear_counts   clears every lane's slip counter
//   o_slip           per-lane one-cycle slip request
//   o_block_lock     per-lane lock status
//   o_all_locked     AND of all lane locks, cycle-aligned with o_block_lock
//   o_slip_count     per-lane saturating slip count, lane i at [8i+7:8i]
module block_lock_multi #(
   parameter int N_LANES     = 1,
   parameter int WINDOW      = 64,
   parameter int INVALID_MAX = 16,
   parameter int SLIP_WAIT   = 0
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [N_LANES-1:0]     i_valid,
   input  logic [2*N_LANES-1:0]   i_header,
   input  logic                   i_clear_counts,
   output logic [N_LANES-1:0]     o_slip,
   output logic [N_LANES-1:0]     o_block_lock,
   output logic                   o_all_locked,
   output logic [8*N_LANES-1:0]   o_slip_count
);

   if (N_LANES < 1 || N_LANES > 8) begin : g_bad_lanes
      $error("N_LANES must be in 1..8");
   end
   if (WINDOW < 2) begin : g_bad_window
      $error("WINDOW must be at least 2");
   end
   if (INVALID_MAX < 1 || INVALID_MAX > WINDOW) begin : g_bad_invalid_max
      $error("INVALID_MAX must be in 1..WINDOW");
   end
   if (SLIP_WAIT < 0 || SLIP_WAIT > 255) begin : g_bad_slip_wait
      $error("SLIP_WAIT must be in 0..255");
   end

   logic [N_LANES-1:0] lock_next;

   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      block_lock_lane #(
         .WINDOW      (WINDOW),
         .INVALID_MAX (INVALID_MAX),
         .SLIP_WAIT   (SLIP_WAIT)
      ) u_lane (
         .clk             (i_clk),
         .reset           (i_reset),
         .valid           (i_valid[i]),
         .header          (i_header[2*i +: 2]),
         .clear_counts    (i_clear_counts),
         .slip            (o_slip[i]),
         .block_lock      (o_block_lock[i]),
         .block_lock_next (lock_next[i]),
         .slip_count      (o_slip_count[8*i +: 8])
      );
   end

   // Registered from next-state locks so it changes on the same edge as o_block_lock.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_all_locked <= 1'b0;
      end else begin
         o_all_locked <= &lock_next;
      end
   end

endmodule

// File: tb/tb_block_lock_multi.sv
module tb_block_lock_multi;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  a_valid;
   logic [7:0]  a_header;
   logic        a_clear;
   logic [3:0]  a_slip;
   logic [3:0]  a_lock;
   logic        a_all;
   logic [31:0] a_count;

   logic        b_valid;
   logic [1:0]  b_header;
   logic        b_clear;
   logic        b_slip;
   logic        b_lock;
   logic        b_all;
   logic [7:0]  b_count;

   block_lock_multi #(.N_LANES(4), .WINDOW(64), .INVALID_MAX(16), .SLIP_WAIT(0)) u_dut_a (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_valid        (a_valid),
      .i_header       (a_header),
      .i_clear_counts (a_clear),
      .o_slip         (a_slip),
      .o_block_lock   (a_lock),
      .o_all_locked   (a_all),
      .o_slip_count   (a_count)
   );

   block_lock_multi #(.N_LANES(1), .WINDOW(64), .INVALID_MAX(16), .SLIP_WAIT(4)) u_dut_b (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_valid        (b_valid),
      .i_header       (b_header),
      .i_clear_counts (b_clear),
      .o_slip         (b_slip),
      .o_block_lock   (b_lock),
      .o_all_locked   (b_all),
      .o_slip_count   (b_count)
   );

   typedef struct {
      logic [3:0]  slip;
      logic [3:0]  lock;
      logic        all;
      logic [31:0] cnt;
      logic        bslip;
      logic        block;
      logic [7:0]  bcnt;
   } exp_t;

   typedef struct {
      int         n;
      logic [1:0] hdr;
      logic       exp_lock;
      int         exp_cnt;
   } vec_t;

   exp_t sb[$];
   int checks   = 0;
   int failures = 0;

   // Reference model: lanes 0..3 belong to DUT A, lane 4 is DUT B.
   int m_state[5];
   int m_cnt[5];
   int m_inv[5];
   int m_wait[5];
   int m_sc[5];
   bit m_lock[5];
   bit m_slip[5];
   int m_sw[5] = '{0, 0, 0, 0, 4};

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int l = 0; l < 5; l++) begin
         m_state[l] = 0; m_cnt[l] = 0; m_inv[l] = 0; m_wait[l] = 0;
         m_sc[l] = 0; m_lock[l] = 1'b0; m_slip[l] = 1'b0;
      end
   endtask

   task automatic m_step(input int l, input bit v, input bit [1:0] h, input bit clr);
      bit good;
      bit s;
      int cn;
      int iv;
      good = h[1] ^ h[0];
      s    = 1'b0;
      if (v) begin
         if (m_state[l] == 0) begin
            cn = m_cnt[l] + 1;
            iv = m_inv[l] + (good ? 0 : 1);
            if (!good && (!m_lock[l] || iv == 16)) begin
               m_lock[l] = 1'b0; s = 1'b1; m_cnt[l] = 0; m_inv[l] = 0;
               m_state[l] = (m_sw[l] == 0) ? 0 : 1;
            end else if (cn == 64) begin
               if (iv == 0) m_lock[l] = 1'b1;
               m_cnt[l] = 0; m_inv[l] = 0;
            end else begin
               m_cnt[l] = cn; m_inv[l] = iv;
            end
         end else begin
            if (m_wait[l] + 1 == m_sw[l]) begin
               m_wait[l] = 0; m_state[l] = 0;
            end else begin
               m_wait[l] = m_wait[l] + 1;
            end
         end
      end
      m_slip[l] = s;
      if (clr) m_sc[l] = 0;
      else if (s && m_sc[l] < 255) m_sc[l] = m_sc[l] + 1;
   endtask

   // Drive one cycle, push the model's expectation, then pop and compare after the edge.
   task automatic cycle(input logic [3:0] va, input logic [7:0] ha, input logic ca,
                        input logic vb, input logic [1:0] hb, input logic r);
      exp_t e;
      exp_t g;
      a_valid = va; a_header = ha; a_clear = ca;
      b_valid = vb; b_header = hb; b_clear = 1'b0;
      rst = r;
      if (r) begin
         m_reset();
      end else begin
         for (int l = 0; l < 4; l++) m_step(l, va[l], ha[2*l +: 2], ca);
         m_step(4, vb, hb, 1'b0);
      end
      for (int l = 0; l < 4; l++) begin
         e.slip[l]       = m_slip[l];
         e.lock[l]       = m_lock[l];
         e.cnt[8*l +: 8] = 8'(m_sc[l]);
      end
      e.all   = &e.lock;
      e.bslip = m_slip[4];
      e.block = m_lock[4];
      e.bcnt  = 8'(m_sc[4]);
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      check("a_slip",  32'(a_slip),  32'(g.slip));
      check("a_lock",  32'(a_lock),  32'(g.lock));
      check("a_all",   32'(a_all),   32'(g.all));
      check("a_count", a_count,      g.cnt);
      check("b_slip",  32'(b_slip),  32'(g.bslip));
      check("b_lock",  32'(b_lock),  32'(g.block));
      check("b_all",   32'(b_all),   32'(g.block));
      check("b_count", 32'(b_count), 32'(g.bcnt));
   endtask

   // Lane 0 gets h0; lanes 1 and 3 always valid headers, lane 2 always invalid.
   task automatic a_run(input int n, input logic [1:0] h0);
      for (int k = 0; k < n; k++) cycle(4'hF, {2'b10, 2'b11, 2'b01, h0}, 1'b0, 1'b0, 2'b01, 1'b0);
   endtask

   task automatic b_run(input int n, input logic [1:0] h);
      for (int k = 0; k < n; k++) cycle(4'h0, 8'h00, 1'b0, 1'b1, h, 1'b0);
   endtask

   vec_t tbl[8];

   initial begin
      tbl[0] = '{9,  2'b01, 1'b0, 0};
      tbl[1] = '{1,  2'b11, 1'b0, 1};
      tbl[2] = '{63, 2'b10, 1'b0, 1};
      tbl[3] = '{1,  2'b01, 1'b1, 1};
      tbl[4] = '{15, 2'b00, 1'b1, 1};
      tbl[5] = '{49, 2'b01, 1'b1, 1};
      tbl[6] = '{15, 2'b11, 1'b1, 1};
      tbl[7] = '{1,  2'b00, 1'b0, 2};

      a_valid = '0; a_header = '0; a_clear = 1'b0;
      b_valid = 1'b0; b_header = '0; b_clear = 1'b0; rst = 1'b1;

      // Reset state
      cycle(4'h0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
      cycle(4'h0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
      check("rst_slip",  32'(a_slip),  32'd0);
      check("rst_lock",  32'(a_lock),  32'd0);
      check("rst_all",   32'(a_all),   32'd0);
      check("rst_count", a_count,      32'd0);

      // Settle: DUT B with SLIP_WAIT=4; invalid headers during the wait are ignored
      b_run(1, 2'b11);
      check("settle_slip", 32'(b_slip), 32'd1);
      b_run(4, 2'b11);
      check("settle_noslip", 32'(b_slip), 32'd0);
      check("settle_count",  32'(b_count), 32'd1);
      b_run(30, 2'b01);
      cycle(4'h0, 8'h00, 1'b0, 1'b0, 2'b11, 1'b0);
      b_run(33, 2'b10);
      check("settle_lock67", 32'(b_lock), 32'd0);
      b_run(1, 2'b01);
      check("settle_lock68", 32'(b_lock), 32'd1);

      // Table: acquire, unlocked error, locked tolerance on lane 0
      for (int t = 0; t < 8; t++) begin
         a_run(tbl[t].n, tbl[t].hdr);
         check("tbl_lock",  32'(a_lock[0]),     32'(tbl[t].exp_lock));
         check("tbl_count", 32'(a_count[7:0]),  32'(tbl[t].exp_cnt));
         if (t == 1 || t == 7) check("tbl_slip", 32'(a_slip[0]), 32'd1);
      end
      check("tbl_all", 32'(a_all), 32'd0);

      // Reset after 40 headers discards progress
      a_run(40, 2'b01);
      cycle(4'h0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
      check("rst2_lock",  32'(a_lock),  32'd0);
      check("rst2_count", a_count,      32'd0);
      check("rst2_block", 32'(b_lock),  32'd0);
      a_run(63, 2'b10);
      check("rst2_lock63", 32'(a_lock[0]), 32'd0);
      a_run(1, 2'b10);
      check("rst2_lock64", 32'(a_lock), 32'b1011);

      // Multi-lane with random gaps
      cycle(4'h0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
      for (int k = 0; k < 1000; k++) begin
         logic [1:0] h0, h1, h2, h3;
         h0 = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
         h1 = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
         h2 = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
         h3 = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
         cycle(4'($urandom), {h3, h2, h1, h0}, 1'b0, 1'b0, 2'b01, 1'b0);
      end
      check("multi_lock",  32'(a_lock),          32'b1011);
      check("multi_all",   32'(a_all),           32'd0);
      check("multi_sat",   32'(a_count[23:16]),  32'd255);
      check("multi_cnt0",  32'(a_count[7:0]),    32'd0);
      cycle(4'b0100, 8'h30, 1'b1, 1'b0, 2'b01, 1'b0);
      check("clear_wins",  32'(a_slip[2]),       32'd1);
      check("clear_count", a_count,              32'd0);
      cycle(4'b0000, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0);
      check("gap_slip",    32'(a_slip),          32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/block_lock_multi.md
# block_lock_multi

Parametrised, multi-lane 64b/66b block-lock state machine for the PCS receive path, per IEEE 802.3 Clause 49 Fig. 49-14 semantics.
- Each lane watches the 2-bit sync header from its gearbox and drives a one-cycle slip request back to that gearbox until 64b/66b alignment is found.
- Each lane reports a true block_lock status once aligned.
- Adds configurable window, invalid threshold and post-slip settle time, per-lane slip statistics, and an aggregate all-lanes-locked flag.

## Interface
- N_LANES, 1, number of independent lanes (1..8)
- WINDOW, 64, valid headers per test window (≥2)
- INVALID_MAX, 16, invalid headers in one window that force loss of lock (1..WINDOW)
- SLIP_WAIT, 0, valid headers discarded after each slip while the gearbox settles (0..255)
- i_clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high, on clock i_clk
- i_valid  in  N_LANES  per-lane header qualifier; lane i at bit i
- i_header  in  2*N_LANES  sync headers; lane i at [2i+1:2i]
- i_clear_counts  in  1  synchronous clear of all slip counters
- o_slip  out  N_LANES  one-cycle slip request per lane
- o_block_lock  out  N_LANES  per-lane block lock
- o_all_locked  out  1  AND of o_block_lock
- o_slip_count  out  8*N_LANES  per-lane saturating slip count; lane i at [8i+7:8i]

## Operation
- Header validity is sh_valid = header[1] XOR header[0]; 2'b01 and 2'b10 are valid, 2'b00 and 2'b11 are invalid.
- Per lane, all state advances only on edges where i_valid[i]=1. With i_valid low, every register holds, except o_slip, which clears.
- Each lane has two states:
  - TEST: counting headers within a window.
  - SLIP_WAIT: discarding headers after a slip.
- TEST, for each accepted header:
  - cnt_n = sh_cnt+1.
  - inv_n = sh_invalid_cnt + !sh_valid.
- TEST decision rules, in priority order:
  1. Header invalid and (block_lock=0 or inv_n==INVALID_MAX):
     - block_lock←0, o_slip←1, counters←0.
     - Go to SLIP_WAIT, or stay in TEST if SLIP_WAIT=0.
  2. cnt_n==WINDOW:
     - If inv_n==0, block_lock←1; otherwise block_lock holds.
     - Counters←0.
  3. Otherwise: sh_cnt←cnt_n, sh_invalid_cnt←inv_n.
- Rule 1 takes priority when it coincides with the window end.
- SLIP_WAIT:
  - wait_cnt increments per accepted header; the header itself is ignored.
  - After SLIP_WAIT headers, clear wait_cnt and return to TEST.
- Slip counter:
  - Increments on each o_slip assertion and saturates at 255.
  - i_clear_counts forces it to 0; if a slip occurs in the same cycle, clear wins.
- Counter widths:
  - sh_cnt and sh_invalid_cnt: $clog2(WINDOW+1) bits.
  - wait_cnt: 8 bits.
- Elaboration $error if any parameter is out of range.

## Timing
- Reset values:
  - o_slip=0, o_block_lock=0, o_all_locked=0, o_slip_count=0.
  - State TEST, all counters 0.
  - Reset mid-window or mid-SLIP_WAIT discards all progress.
- All outputs are registered; o_all_locked is registered from the next-state lock vector, so it aligns with o_block_lock.
- o_block_lock rises in the cycle after the edge that samples the WINDOW-th consecutive valid header.
- o_slip is high exactly one cycle: the cycle after the edge that samples the failing header. It never asserts on back-to-back cycles unless headers are accepted on consecutive edges.
- After a slip, the first SLIP_WAIT accepted headers are ignored; the (SLIP_WAIT+1)-th accepted header is the first header of a new window.
- Lanes are fully independent; simultaneous slips on several lanes are all reported in the same cycle.

## Structure
- Package pcs_lock_pkg holds:
  - lock_state_t enum {TEST, SLIP_WAIT}
  - localparams SYNC_DATA=2'b01 and SYNC_CTRL=2'b10
  - function sh_is_valid()
- Sub-module block_lock_lane implements one lane: FSM, counters and slip counter.
- The top generates N_LANES instances and forms o_all_locked.

## Test plan
- Acquire: N_LANES=1, defaults, 64 valid headers on consecutive cycles → o_block_lock=1 the cycle after header 64, o_slip never high.
- Unlocked error: invalid header 2'b11 at position 10 → o_slip pulse next cycle, slip_count=1, window restarts at header 11.
- Locked tolerance: after lock, a window with 15 invalid headers → lock held. Next window with 16 invalid → o_slip pulse on the 16th, o_block_lock=0 the same cycle, slip_count=2.
- Settle: SLIP_WAIT=4, one invalid while unlocked → 4 headers ignored; then 64 valid → lock after header 68 counted from the slip.
- Multi-lane with gaps:
  - N_LANES=4; lane 2 is fed invalid headers, the others valid; i_valid toggles randomly.
  - Lanes 0, 1 and 3 lock after 64 accepted headers; lane 2 slips on every accepted header, and its counter saturates at 255 then clears on i_clear_counts.
  - o_all_locked stays 0.
- Reset mid-operation: i_reset after 40 valid headers → all outputs 0 next cycle; lock requires a full 64 more headers.
